gray_to_bcd_packer: RTL

- Decoder side of the BCD-to-Gray digit path: accepts a stream of 4-bit Gray-coded decimal digits over a valid/ready handshake.
- Converts each digit back to binary-coded decimal.
- Packs NDIG consecutive digits, most-significant first, into one BCD word.
- Presents the word on a valid/ready output handshake with an invalid-digit flag. Sits between the Gray-coded digit source and any BCD display or arithmetic consumer.

---
 rtl/gray_to_bcd_packer.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/gray_to_bcd_packer.sv
// gray_to_bcd_packer
// Accepts Gray-coded decimal digits on a valid/ready input, decodes each back
// to BCD and packs NDIG of them (most-significant first) into one output word
// presented on a valid/ready output with a sticky invalid-digit flag.
//
// Optional build macro: GRAY_STEP_CHECK_EN
//   When defined, consecutive Gray codes within a word are checked for a
//   single-bit step and a sticky out_step_err flag is presented with the word.
//   When undefined, the out_step_err port and all step-check state disappear.
module gray_to_bcd_packer #(
  parameter int NDIG = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_gray,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4*NDIG-1:0] out_bcd,
  output logic              out_err
`ifdef GRAY_STEP_CHECK_EN
  ,
  output logic              out_step_err
`endif
);

  // Digit counter width; a single-digit word still needs one bit to exist.
  localparam int            CW       = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NDIG - 1);

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  state_t            state_reg, state_next;
  logic [CW-1:0]     cnt_reg, cnt_next;
  logic [4*NDIG-1:0] word_reg, word_next;
  logic              err_reg, err_next;

  logic [3:0]        bin_digit;
  logic              digit_invalid;
  logic              in_fire;
  logic              out_fire;
  logic              last_digit;
  logic [NDIG-1:0]   nib_we;

  // Handshake strobes come straight from the state register so there is no
  // combinational path from in_valid to in_ready or out_ready to out_valid.
  assign in_ready   = (state_reg == COLLECT);
  assign out_valid  = (state_reg == HOLD);
  assign in_fire    = in_valid && in_ready;
  assign out_fire   = out_valid && out_ready;
  assign last_digit = (cnt_reg == LAST_CNT);

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_decode
      assign bin_digit[gi] = ^in_gray[3:gi];
    end
  endgenerate

  // Codes 1010..1111 are not decimal digits; they are stored as-is but flagged.
  assign digit_invalid = (bin_digit > 4'd9);

  // Nibble write enables and next word: the first digit lands in the top nibble,
  // so nibble gi is written when the counter equals NDIG-1-gi.
  generate
    for (gi = 0; gi < NDIG; gi++) begin : g_nibble
      localparam logic [CW-1:0] SLOT = CW'(NDIG - 1 - gi);
      assign nib_we[gi] = in_fire && (cnt_reg == SLOT);
      assign word_next[4*gi +: 4] = out_fire   ? 4'h0 :
                                    nib_we[gi] ? bin_digit :
                                                 word_reg[4*gi +: 4];
    end
  endgenerate

  // Next-state logic: collect NDIG digits, then hold the word until taken.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    err_next   = err_reg;
    case (state_reg)
      COLLECT: begin
        if (in_fire) begin
          err_next = err_reg | digit_invalid;
          if (last_digit) begin
            cnt_next   = '0;
            state_next = HOLD;
          end else begin
            cnt_next = cnt_reg + CW'(1);
          end
        end
      end
      HOLD: begin
        // Input is blocked here, so the output handshake never overlaps a capture.
        if (out_fire) begin
          state_next = COLLECT;
          err_next   = 1'b0;
        end
      end
      default: state_next = COLLECT;
    endcase
  end

  // State, counter, word and error registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= COLLECT;
      cnt_reg   <= '0;
      word_reg  <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      word_reg  <= word_next;
      err_reg   <= err_next;
    end
  end

  // Outputs read as zero whenever no completed word is being offered.
  assign out_bcd = out_valid ? word_reg : '0;
  assign out_err = out_valid && err_reg;

`ifdef GRAY_STEP_CHECK_EN
  logic [3:0] prev_reg, prev_next;
  logic       step_err_reg, step_err_next;
  logic [3:0] step_diff;
  logic       step_bad;

  // A legal Gray step changes exactly one bit: diff is non-zero and a power of two.
  assign step_diff = in_gray ^ prev_reg;
  assign step_bad  = (step_diff == 4'h0) || ((step_diff & (step_diff - 4'h1)) != 4'h0);

  // Track the previous code inside a word; the first digit has no predecessor.
  always_comb begin
    prev_next     = prev_reg;
    step_err_next = step_err_reg;
    if (out_fire) begin
      prev_next     = 4'h0;
      step_err_next = 1'b0;
    end else if (in_fire) begin
      prev_next = in_gray;
      if ((cnt_reg != '0) && step_bad) begin
        step_err_next = 1'b1;
      end
    end
  end

  // Step-check registers share the word's reset and clear timing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_reg     <= 4'h0;
      step_err_reg <= 1'b0;
    end else begin
      prev_reg     <= prev_next;
      step_err_reg <= step_err_next;
    end
  end

  assign out_step_err = out_valid && step_err_reg;
`endif

endmodule
